// File: rtl/uart_led_cmd_ctrl_pkg.sv
// Shared types and constants for the UART LED command controller.
// Holds the FSM state encoding, command bytes, acknowledge bytes and mode selects.
package uart_led_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        ACK_WAIT = 2'd2,
        ACK_SEND = 2'd3
    } ctrl_state_t;

    localparam logic [7:0] CMD_MODE0 = 8'h30;
    localparam logic [7:0] CMD_MODE1 = 8'h31;
    localparam logic [7:0] CMD_MODE2 = 8'h32;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_STOP  = 8'h53;

    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_BAD = 8'h3F;

    localparam logic [1:0] MODE_RAW   = 2'd0;
    localparam logic [1:0] MODE_STATS = 2'd1;
    localparam logic [1:0] MODE_SHOW  = 2'd2;

    function automatic logic is_mode_cmd(input logic [7:0] b);
        return (b == CMD_MODE0) || (b == CMD_MODE1) || (b == CMD_MODE2);
    endfunction

endpackage

// File: rtl/uart_led_cmd_ctrl_sat_counter.sv
// Saturating up-counter; inc adds 1, inc2 adds 2, both together add 3.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         inc2,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

    logic [W+1:0] sum;

    always_comb begin
        sum = {2'b00, count} + {{W{1'b0}}, inc2, inc};
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (sum > MAX) begin
            count <= '1;
        end else begin
            count <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Command sequencer: decodes single-byte RX commands into sel/done for the LED
// show engine, acknowledges each one on TX and muxes the LED banks.
module uart_led_cmd_ctrl
    import uart_led_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_err,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic [7:0]  show_left,
    input  logic [7:0]  show_right,
    output logic [1:0]  sel,
    output logic        done,
    output logic [7:0]  left_leds,
    output logic [7:0]  right_leds,
    output ctrl_state_t state
);

    // Handshakes: rx_valid/rx_err are single-cycle strobes with no backpressure;
    // a byte is only accepted in IDLE. tx_start is a one-cycle request issued
    // only in a cycle after tx_busy was seen low, and tx_data is held stable.

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TOUT_LAST = TW'(ACK_TIMEOUT - 1);

    logic [7:0]       cmd_reg;
    logic [7:0]       last_byte;
    logic [TW-1:0]    tout;
    logic [CNT_W-1:0] cmd_cnt;
    logic [CNT_W-1:0] err_cnt;

    logic       cmd_known;
    logic       cmd_ok;
    logic [7:0] ack_byte;
    logic       overrun;
    logic       fsm_err;
    logic       ack_timeout;
    logic [1:0] err_events;

    always_comb begin
        cmd_known = is_mode_cmd(cmd_reg) || (cmd_reg == CMD_GO) || (cmd_reg == CMD_STOP);
        cmd_ok    = is_mode_cmd(cmd_reg) || (cmd_reg == CMD_STOP) ||
                    ((cmd_reg == CMD_GO) && (sel == MODE_SHOW));
        ack_byte  = cmd_ok ? ACK_OK : ACK_BAD;
    end

    // A refused GO is acknowledged as bad but is not counted as an error.
    always_comb begin
        overrun     = rx_valid && (state != IDLE);
        ack_timeout = (state == ACK_WAIT) && tx_busy && (tout == TOUT_LAST);
        fsm_err     = ((state == DECODE) && !cmd_known) || ack_timeout;
        err_events  = {1'b0, rx_err} + {1'b0, overrun} + {1'b0, fsm_err};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= MODE_RAW;
            done      <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            cmd_reg   <= 8'h00;
            last_byte <= 8'h00;
            tout      <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cmd_reg   <= rx_data;
                        last_byte <= rx_data;
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    tx_data <= ack_byte;
                    tout    <= '0;
                    state   <= ACK_WAIT;
                    if (is_mode_cmd(cmd_reg)) begin
                        sel  <= cmd_reg[1:0];
                        done <= 1'b0;
                    end else if (cmd_reg == CMD_GO) begin
                        if (sel == MODE_SHOW) begin
                            done <= 1'b1;
                        end
                    end else if (cmd_reg == CMD_STOP) begin
                        done <= 1'b0;
                    end
                end
                ACK_WAIT: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= ACK_SEND;
                    end else if (tout == TOUT_LAST) begin
                        state <= IDLE;
                    end else begin
                        tout <= tout + 1'b1;
                    end
                end
                ACK_SEND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cmd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ((state == DECODE) && cmd_ok),
        .inc2  (1'b0),
        .clr   (1'b0),
        .count (cmd_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_events[0]),
        .inc2  (err_events[1]),
        .clr   (1'b0),
        .count (err_cnt)
    );

    logic [7:0] cmd_led;
    logic [7:0] err_led;

    generate
        if (CNT_W >= 8) begin : g_wide
            assign cmd_led = cmd_cnt[7:0];
            assign err_led = err_cnt[7:0];
        end else begin : g_narrow
            assign cmd_led = {{(8 - CNT_W){1'b0}}, cmd_cnt};
            assign err_led = {{(8 - CNT_W){1'b0}}, err_cnt};
        end
    endgenerate

    always_comb begin
        left_leds  = 8'h00;
        right_leds = 8'h00;
        case (sel)
            MODE_RAW: begin
                left_leds = last_byte;
            end
            MODE_STATS: begin
                left_leds  = cmd_led;
                right_leds = err_led;
            end
            MODE_SHOW: begin
                if (done) begin
                    left_leds  = show_left;
                    right_leds = show_right;
                end
            end
            default: begin
                left_leds  = 8'h00;
                right_leds = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Directed bench for uart_led_cmd_ctrl: command decode, acks, LED mux,
// ack timeout, overrun, reset abort and error counter saturation.
module tb_uart_led_cmd_ctrl;
    import uart_led_pkg::*;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_err;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [7:0]  show_left;
    logic [7:0]  show_right;
    logic [1:0]  sel;
    logic        done;
    logic [7:0]  left_leds;
    logic [7:0]  right_leds;
    ctrl_state_t state;

    int n_checks;
    int n_fail;

    uart_led_cmd_ctrl #(.ACK_TIMEOUT(255), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .show_left  (show_left),
        .show_right (show_right),
        .sel        (sel),
        .done       (done),
        .left_leds  (left_leds),
        .right_leds (right_leds),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle N+2, where N is the cycle rx_valid was high.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic wait_ack(input logic [7:0] exp, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
        check({tag, "_data"}, 32'(tx_data), 32'(exp));
        tick();
        check({tag, "_idle"}, 32'(state), 32'(IDLE));
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] e_sel, input logic e_done,
                                 input logic [7:0] e_left, input logic [7:0] e_right);
        check({tag, "_sel"}, 32'(sel), 32'(e_sel));
        check({tag, "_done"}, 32'(done), 32'(e_done));
        check({tag, "_left"}, 32'(left_leds), 32'(e_left));
        check({tag, "_right"}, 32'(right_leds), 32'(e_right));
    endtask

    initial begin
        logic any_start;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        rx_err     = 1'b0;
        tx_busy    = 1'b0;
        show_left  = 8'h80;
        show_right = 8'h01;
        repeat (3) tick();
        reset = 1'b0;

        check_outputs("rst", 2'd0, 1'b0, 8'h00, 8'h00);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));

        // '2': sel=2, done stays 0, show LEDs blanked
        rx_valid = 1'b1;
        rx_data  = 8'h32;
        tick();
        rx_valid = 1'b0;
        check("m2_decode", 32'(state), 32'(DECODE));
        tick();
        check_outputs("m2", 2'd2, 1'b0, 8'h00, 8'h00);
        check("m2_no_early_start", 32'(tx_start), 32'd0);
        wait_ack(8'h4B, "m2_ack");

        send(8'h47);
        check_outputs("go", 2'd2, 1'b1, 8'h80, 8'h01);
        wait_ack(8'h4B, "go_ack");

        send(8'h53);
        check_outputs("stop", 2'd2, 1'b0, 8'h00, 8'h00);
        wait_ack(8'h4B, "stop_ack");

        send(8'h30);
        check_outputs("m0", 2'd0, 1'b0, 8'h30, 8'h00);
        wait_ack(8'h4B, "m0_ack");

        // GO refused outside show mode
        send(8'h47);
        check_outputs("go_bad", 2'd0, 1'b0, 8'h47, 8'h00);
        wait_ack(8'h3F, "go_bad_ack");

        send(8'h7A);
        check_outputs("inval", 2'd0, 1'b0, 8'h7A, 8'h00);
        wait_ack(8'h3F, "inval_ack");

        // stats view: cmd_cnt=5, err_cnt=1
        send(8'h31);
        check_outputs("m1", 2'd1, 1'b0, 8'h05, 8'h01);
        wait_ack(8'h4B, "m1_ack");

        // ack timeout: busy held for ACK_TIMEOUT+5 cycles
        tx_busy = 1'b1;
        send(8'h31);
        check_outputs("to_start", 2'd1, 1'b0, 8'h06, 8'h01);
        any_start = 1'b0;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (tx_start) any_start = 1'b1;
        end
        check("to_no_start", 32'(any_start), 32'd0);
        check("to_state", 32'(state), 32'(IDLE));
        check_outputs("to_end", 2'd1, 1'b0, 8'h06, 8'h02);

        // overrun during ACK_WAIT
        send(8'h53);
        check("ovr_wait", 32'(state), 32'(ACK_WAIT));
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        tick();
        rx_valid = 1'b0;
        check_outputs("ovr", 2'd1, 1'b0, 8'h07, 8'h03);
        tx_busy = 1'b0;
        wait_ack(8'h4B, "ovr_ack");
        check_outputs("ovr_after", 2'd1, 1'b0, 8'h07, 8'h03);

        // rx_err coincident with invalid-byte decode: +2
        rx_valid = 1'b1;
        rx_data  = 8'h7A;
        tick();
        rx_valid = 1'b0;
        rx_err   = 1'b1;
        tick();
        rx_err   = 1'b0;
        check_outputs("dbl", 2'd1, 1'b0, 8'h07, 8'h05);
        wait_ack(8'h3F, "dbl_ack");

        // reset while waiting for the transmitter
        tx_busy = 1'b1;
        send(8'h32);
        check("rw_wait", 32'(state), 32'(ACK_WAIT));
        reset   = 1'b1;
        tx_busy = 1'b0;
        tick();
        reset = 1'b0;
        check_outputs("rw", 2'd0, 1'b0, 8'h00, 8'h00);
        check("rw_tx_start", 32'(tx_start), 32'd0);
        check("rw_tx_data", 32'(tx_data), 32'd0);
        check("rw_state", 32'(state), 32'(IDLE));
        any_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_start) any_start = 1'b1;
        end
        check("rw_no_start", 32'(any_start), 32'd0);

        // saturation: 300 invalid bytes
        for (int i = 0; i < 300; i++) begin
            send(8'h7A);
            wait_ack(8'h3F, "sat_ack");
        end
        send(8'h31);
        check_outputs("sat", 2'd1, 1'b0, 8'h01, 8'hFF);
        wait_ack(8'h4B, "sat_m1_ack");
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        check_outputs("sat_hold", 2'd1, 1'b0, 8'h01, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_led_cmd_ctrl.md
Name: uart_led_cmd_ctrl

Overview:
- Command sequencer between the UART receiver/transmitter and the LED show engine.
- Decodes single-byte ASCII commands from the RX path into a mode select (`sel`) and run enable (`done`) for the LED show engine.
- Sends a one-byte acknowledge through the TX path for every command.
- Multiplexes the left/right LED banks between three sources: raw RX byte, statistics counters, and the show pattern.

Parameters:
- ACK_TIMEOUT, 255: max cycles spent waiting for `tx_busy` low before an acknowledge is dropped.
- CNT_W, 8: width of the command and error statistics counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe; `rx_data` is valid
- rx_data  in  8  received byte
- rx_err  in  1  one-cycle strobe; framing error on the RX path
- tx_busy  in  1  transmitter is occupied
- tx_start  out  1  one-cycle request to send `tx_data`
- tx_data  out  8  acknowledge byte
- show_left  in  8  left LED pattern from the show engine
- show_right  in  8  right LED pattern from the show engine
- sel  out  2  mode select to the show engine
- done  out  1  run enable to the show engine
- left_leds  out  8  left LED bank
- right_leds  out  8  right LED bank

Behaviour:
- Reset (sync, active-high) values:
  - `sel` = 0, `done` = 0, `tx_start` = 0, `tx_data` = 0.
  - `last_byte` = 0, `cmd_cnt` = 0, `err_cnt` = 0.
  - FSM state = IDLE.
  - Reset mid-transaction abandons any pending acknowledge; no `tx_start` is issued afterwards.
- FSM states: IDLE, DECODE, ACK_WAIT, ACK_SEND.
- IDLE:
  - On `rx_valid`: capture `rx_data` into `cmd_reg` and `last_byte`, then go to DECODE.
  - `rx_valid` arriving in any other state is ignored and increments `err_cnt` (overrun).
- DECODE (exactly 1 cycle):
  - '0' (0x30), '1' (0x31), '2' (0x32): `sel` = low 2 bits; `done` forced to 0. Ack 'K' (0x4B).
  - 'G' (0x47): `done` = 1 only if `sel` == 2, ack 'K'; otherwise `done` unchanged, ack '?' (0x3F).
  - 'S' (0x53): `done` = 0, ack 'K'.
  - Any other byte: no state change, ack '?', `err_cnt` +1.
  - `cmd_cnt` +1 on every 'K'.
  - Load `tx_data` with the ack byte, zero the timeout counter, go to ACK_WAIT.
- ACK_WAIT:
  - `tx_busy` == 0: go to ACK_SEND.
  - Otherwise increment the timeout counter; when it reaches ACK_TIMEOUT, increment `err_cnt`, drop the ack, and go to IDLE.
- ACK_SEND (exactly 1 cycle): `tx_start` = 1, then go to IDLE.
- Latency:
  - `rx_valid` at cycle N → `sel`/`done` update visible at N+2.
  - `tx_start` asserted no earlier than N+3.
- `rx_err` strobe in any state: `err_cnt` +1; FSM unaffected.
- If `rx_err` and an overrun/invalid increment occur in the same cycle, `err_cnt` increases by 2.
- Counters saturate at 2^CNT_W − 1; they never wrap.
- LED mux (combinational from registered state):
  - `sel` == 0: `left_leds` = `last_byte`, `right_leds` = 0.
  - `sel` == 1: `left_leds` = `cmd_cnt`, `right_leds` = `err_cnt` (low 8 bits).
  - `sel` == 2: `left_leds`/`right_leds` = `show_left`/`show_right` when `done` = 1, else both 0.
  - `sel` == 3 (unreachable by command): both 0.

Decomposition:
- Shared package `uart_led_pkg` holds:
  - state enum `ctrl_state_t`.
  - command constants CMD_MODE0/1/2, CMD_GO, CMD_STOP.
  - ack constants ACK_OK = 0x4B, ACK_BAD = 0x3F.
  - mode constants MODE_RAW = 0, MODE_STATS = 1, MODE_SHOW = 2.
- One sub-module is natural: `sat_counter` (parameter W; inputs `inc`, `inc2`, `clr`), instantiated for `cmd_cnt` and `err_cnt`.
- Decode and LED mux stay inline.

Test Plan:
- After reset, byte '2' with `tx_busy` = 0:
  - `sel` = 2 at N+2, `done` = 0.
  - `tx_start` pulse with `tx_data` = 0x4B.
  - `cmd_cnt` = 1.
- '2' then 'G', with `show_left` = 0x80:
  - `done` = 1 and `left_leds` = 0x80.
  - Then 'S': `done` = 0 and `left_leds` = 0x00.
- 'G' while `sel` = 0: `done` stays 0, ack 0x3F; byte 0x7A: ack 0x3F and `err_cnt` +1.
- `tx_busy` held high for ACK_TIMEOUT + 5 cycles after '1':
  - No `tx_start`; `err_cnt` = 1; FSM returns to IDLE.
  - `sel` = 1 and LEDs show `cmd_cnt`/`err_cnt`.
- Overrun and reset cases:
  - Second `rx_valid` during ACK_WAIT is ignored with `err_cnt` +1.
  - Assert `reset` during ACK_WAIT: all outputs 0 on the next cycle and no `tx_start` thereafter.
- Counter saturation and simultaneous events:
  - 300 invalid bytes with CNT_W = 8: `err_cnt` saturates at 255.
  - `rx_err` coincident with an invalid byte: `err_cnt` +2.
